// File: rtl/bin2bcd_seq_display.sv
// Sequential binary-to-decimal seven-segment display driver.
// A start captures value (unsigned or two's complement) and runs an iterative
// shift-and-add-3 (double dabble) conversion, one bit per clock. The finished
// result is decoded into active-low digits with leading-zero blanking, a sign
// digit and an overflow indication (all digits show a dash on overflow).
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   value        binary input, captured when a start is accepted
//   signed_mode  1 = value is two's complement, captured with value
//   start        conversion request, accepted in idle or done
//   busy         high while shifting
//   done         one-cycle pulse when the display outputs update
//   overflow     last result did not fit in DIGITS digits
//   hex          DIGITS digits, digit k at [7k+6:7k], bit0=a .. bit6=g, active-low
//   hex_sign     sign digit, same encoding
module bin2bcd_seq_display #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex,
  output logic [6:0]            hex_sign
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegDash  = 7'h3F;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                neg_q, neg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic [6:0]          sign_q, sign_d;
  logic                ovf_out_q, ovf_out_d;

  logic                accept;
  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW-1:0]     bcd_sh;
  logic [WIDTH-1:0]    mag_sh;
  logic                shift_out;
  logic                ovf_sh;
  logic                lead;
  logic [3:0]          nib;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SegBlank;
    endcase
  endfunction

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: state-decoded flags plus the result registers
  always_comb begin
    busy     = (state_q == StShift);
    done     = (state_q == StDone);
    overflow = ovf_out_q;
    hex      = hex_q;
    hex_sign = sign_q;
  end

  // Datapath next-state
  always_comb begin
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    sign_d    = sign_q;
    ovf_out_d = ovf_out_q;
    lead      = 1'b1;
    nib       = '0;

    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    {shift_out, bcd_sh, mag_sh} = {bcd_adj, mag_q, 1'b0};
    ovf_sh = ovf_q | shift_out;

    if (accept) begin
      neg_d = signed_mode & value[WIDTH-1];
      mag_d = neg_d ? (~value + WIDTH'(1)) : value;
      bcd_d = '0;
      ovf_d = 1'b0;
      cnt_d = CntW'(WIDTH);
    end else if (state_q == StShift) begin
      mag_d = mag_sh;
      bcd_d = bcd_sh;
      ovf_d = ovf_sh;
      cnt_d = cnt_q - CntW'(1);
      // Last shift: decode the freshly shifted BCD straight into the display
      if (cnt_q == CntW'(1)) begin
        if (ovf_sh) begin
          hex_d     = {DIGITS{SegDash}};
          sign_d    = SegBlank;
          ovf_out_d = 1'b1;
        end else begin
          for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            nib = bcd_sh[4*k +: 4];
            if (nib != 4'd0) lead = 1'b0;
            hex_d[7*k +: 7] = (lead && (k != 0)) ? SegBlank : seg7(nib);
          end
          // Magnitude zero only arises from a non-negative input, so no "-0"
          sign_d    = neg_q ? SegDash : SegBlank;
          ovf_out_d = 1'b0;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      hex_q     <= {DIGITS{SegBlank}};
      sign_q    <= SegBlank;
      ovf_out_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      sign_q    <= sign_d;
      ovf_out_q <= ovf_out_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq_display.sv
// Scoreboard bench for bin2bcd_seq_display: a 4-digit and a 2-digit instance
// receive identical stimulus; expected results come from an integer model.
module tb_bin2bcd_seq_display;

  localparam int W = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  value = '0;
  logic          signed_mode = 1'b0;
  logic          start = 1'b0;

  logic          busy4, done4, ovf4;
  logic [27:0]   hex4;
  logic [6:0]    sign4;
  logic          busy2, done2, ovf2;
  logic [13:0]   hex2;
  logic [6:0]    sign2;

  always #5 clk = ~clk;

  bin2bcd_seq_display #(.WIDTH(W), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .value(value), .signed_mode(signed_mode), .start(start),
    .busy(busy4), .done(done4), .overflow(ovf4), .hex(hex4), .hex_sign(sign4)
  );

  bin2bcd_seq_display #(.WIDTH(W), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value), .signed_mode(signed_mode), .start(start),
    .busy(busy2), .done(done2), .overflow(ovf2), .hex(hex2), .hex_sign(sign2)
  );

  typedef struct {
    logic [27:0] hex;
    logic [6:0]  sign;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk) cyc++;

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Decimal rendering straight from the arithmetic value
  function automatic exp_t model(input logic [W-1:0] v, input logic sm, input int digits,
                                 input int due);
    exp_t e;
    int   m;
    bit   neg;
    bit   ov;
    neg = sm && v[W-1];
    m   = neg ? (1 << W) - int'(v) : int'(v);
    ov  = (m >= pow10(digits));
    e.hex = '0;
    for (int k = 0; k < digits; k++) begin
      if (ov)                         e.hex[7*k +: 7] = 7'h3F;
      else if (k > 0 && m < pow10(k)) e.hex[7*k +: 7] = 7'h7F;
      else                            e.hex[7*k +: 7] = seg_tab[(m / pow10(k)) % 10];
    end
    e.sign = (!ov && neg) ? 7'h3F : 7'h7F;
    e.ovf  = ov;
    e.cyc  = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_entry(input string tag, input exp_t e, input logic [27:0] h,
                             input logic [6:0] s, input logic o, input logic b);
    check({tag, "_hex"}, 32'(h), 32'(e.hex));
    check({tag, "_sign"}, 32'(s), 32'(e.sign));
    check({tag, "_overflow"}, 32'(o), 32'(e.ovf));
    check({tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
    check({tag, "_busy_in_done"}, 32'(b), 32'(0));
  endtask

  // Start at the next negedge; the accepting edge is cyc+1, done shows W edges later
  task automatic issue(input logic [W-1:0] v, input logic sm, input bit track);
    @(negedge clk);
    value = v;
    signed_mode = sm;
    start = 1'b1;
    if (track) begin
      q4.push_back(model(v, sm, 4, cyc + 1 + W));
      q2.push_back(model(v, sm, 2, cyc + 1 + W));
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy4), 32'(1));
  endtask

  task automatic finish_conv(input int gap);
    repeat (W - 1 + gap) @(negedge clk);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_busy"}, 32'(busy4), 32'(0));
    check({tag, "_done"}, 32'(done4), 32'(0));
    check({tag, "_overflow"}, 32'(ovf4), 32'(0));
    check({tag, "_hex"}, 32'(hex4), 32'h0FFF_FFFF);
    check({tag, "_sign"}, 32'(sign4), 32'h7F);
    check({tag, "_hex2"}, 32'(hex2), 32'h3FFF);
    check({tag, "_sign2"}, 32'(sign2), 32'h7F);
  endtask

  initial begin
    fork
      // Monitor: pops an expectation whenever an instance pulses done
      forever begin
        @(negedge clk);
        if (done4 === 1'b1) begin
          if (q4.size() == 0) check("d4_unexpected_done", 32'(1), 32'(0));
          else check_entry("d4", q4.pop_front(), hex4, sign4, ovf4, busy4);
        end
        if (done2 === 1'b1) begin
          if (q2.size() == 0) check("d2_unexpected_done", 32'(1), 32'(0));
          else check_entry("d2", q2.pop_front(), {14'd0, hex2}, sign2, ovf2, busy2);
        end
      end
    join_none

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_blank("reset");
    rst_n = 1'b1;

    // Directed conversions
    issue(10'd3, 1'b0, 1);    finish_conv(0);
    issue(10'd1023, 1'b0, 1); finish_conv(1);
    issue(10'h3FF, 1'b1, 1);  finish_conv(2);
    issue(10'h200, 1'b1, 1);  finish_conv(0);
    issue(10'd0, 1'b1, 1);    finish_conv(1);
    issue(10'd0, 1'b0, 1);    finish_conv(0);
    issue(10'd99, 1'b0, 1);   finish_conv(0);
    issue(10'd100, 1'b0, 1);  finish_conv(0);
    issue(10'd5, 1'b0, 1);    finish_conv(3);

    // Start and a changed value during shifting are ignored
    issue(10'd678, 1'b0, 1);
    repeat (3) @(negedge clk);
    value = 10'd111;
    signed_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W - 5 + 2) @(negedge clk);

    // Start held high: back-to-back conversions, one every W+1 cycles
    @(negedge clk);
    value = 10'd517;
    signed_mode = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q4.push_back(model(10'd517, 1'b0, 4, cyc + 1 + W + k * (W + 1)));
      q2.push_back(model(10'd517, 1'b0, 2, cyc + 1 + W + k * (W + 1)));
    end
    repeat (2 * W + 3) @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // Reset in the middle of a conversion aborts it
    issue(10'd777, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_blank("abort");
    repeat (W + 2) @(negedge clk);
    issue(10'h2F1, 1'b1, 1); finish_conv(1);

    // Randomised conversions with random gaps
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), 1);
      finish_conv(int'($urandom_range(0, 3)));
    end

    // Drain, bounded
    for (int i = 0; i < 100 && (q4.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    check("pending_d4", 32'(q4.size()), 32'(0));
    check("pending_d2", 32'(q2.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
